// File: rtl/audio_pacer_pkg.sv
// Shared definitions for the audio sample pacer: FSM state encoding,
// output mode encoding and the underrun counter width plus its
// saturating increment helper.
package audio_pacer_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      COUNT   = 3'd1,
      READ    = 3'd2,
      CAPTURE = 3'd3,
      MIX     = 3'd4
   } pacer_state_t;

   localparam logic [1:0] MODE_AVG    = 2'd0;
   localparam logic [1:0] MODE_SINGLE = 2'd1;
   localparam logic [1:0] MODE_ADC    = 2'd2;
   localparam logic [1:0] MODE_MUTE   = 2'd3;

   localparam int UNDERRUN_W = 16;

   // Increment that sticks at all-ones instead of wrapping.
   function automatic logic [UNDERRUN_W-1:0] sat_inc(input logic [UNDERRUN_W-1:0] value);
      logic [UNDERRUN_W-1:0] result;
      if (value == {UNDERRUN_W{1'b1}}) begin
         result = value;
      end else begin
         result = value + {{(UNDERRUN_W-1){1'b0}}, 1'b1};
      end
      return result;
   endfunction

endpackage

// File: rtl/audio_channel_mixer.sv
// Combinational sample mixer: averages all channels, picks one channel,
// passes the ADC sample through or mutes, and truncates the chosen value
// to its top OUT_WIDTH bits. The caller registers the result.
module audio_channel_mixer
   import audio_pacer_pkg::*;
#(
   parameter int NUM_CH    = 2,
   parameter int IN_WIDTH  = 32,
   parameter int ADC_WIDTH = 24,
   parameter int OUT_WIDTH = 12,
   parameter int SEL_W     = 1
) (
   input  logic [NUM_CH*IN_WIDTH-1:0] ch_flat,
   input  logic [1:0]                 mode,
   input  logic [SEL_W-1:0]           chan_sel,
   input  logic [ADC_WIDTH-1:0]       adc_data,
   output logic [OUT_WIDTH-1:0]       mix_out
);

   localparam int LOG_CH = (NUM_CH > 1) ? $clog2(NUM_CH) : 0;
   localparam int SUM_W  = IN_WIDTH + LOG_CH;

   logic signed [SUM_W-1:0] sum_s;
   logic signed [SUM_W-1:0] avg_s;
   logic [IN_WIDTH-1:0]     single_word_s;
   int                      sel_idx_s;
   logic                    unused_s;

   // Sign-extended sum wide enough that no channel combination can overflow.
   always_comb begin
      sum_s = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         sum_s = sum_s + SUM_W'($signed(ch_flat[i*IN_WIDTH +: IN_WIDTH]));
      end
      avg_s = sum_s >>> LOG_CH;
   end

   // Out-of-range channel selects fall back to channel 0.
   always_comb begin
      if (int'(chan_sel) < NUM_CH) begin
         sel_idx_s = int'(chan_sel);
      end else begin
         sel_idx_s = 0;
      end
      single_word_s = ch_flat[sel_idx_s*IN_WIDTH +: IN_WIDTH];
   end

   // Mode multiplexer; each source contributes only its top OUT_WIDTH bits.
   always_comb begin
      mix_out = '0;
      case (mode)
         MODE_AVG:    mix_out = avg_s[IN_WIDTH-1 -: OUT_WIDTH];
         MODE_SINGLE: mix_out = single_word_s[IN_WIDTH-1 -: OUT_WIDTH];
         MODE_ADC:    mix_out = adc_data[ADC_WIDTH-1 -: OUT_WIDTH];
         MODE_MUTE:   mix_out = '0;
         default:     mix_out = '0;
      endcase
   end

   // Low-order bits are deliberately dropped by the truncation above.
   assign unused_s = ^{avg_s, single_word_s, adc_data};

endmodule

// File: rtl/audio_sample_pacer.sv
// Frame pacer: every P = max(period, NUM_CH+3) cycles it reads one FIFO
// word per channel, mixes them and emits a held sample with a one-cycle
// valid pulse. Frame start to sample_valid latency is exactly P cycles.
// Optional feature macro: AUDIO_PACER_UNDERRUN_EN -- skip reads when the
// FIFO is empty, hold that channel, and count the missed slots.
module audio_sample_pacer
   import audio_pacer_pkg::*;
#(
   parameter int NUM_CH    = 2,
   parameter int IN_WIDTH  = 32,
   parameter int ADC_WIDTH = 24,
   parameter int OUT_WIDTH = 12,
   parameter int CNT_WIDTH = 16,
   parameter int SEL_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  enable,
   input  logic [CNT_WIDTH-1:0]  period,
   input  logic [1:0]            mode,
   input  logic [SEL_W-1:0]      chan_sel,
   input  logic [IN_WIDTH-1:0]   fifo_dout,
   input  logic                  fifo_empty,
   output logic                  fifo_rd_en,
   input  logic [ADC_WIDTH-1:0]  adc_data,
   output logic [OUT_WIDTH-1:0]  audio_data,
   output logic                  sample_valid,
   output logic [UNDERRUN_W-1:0] underrun_count
);

   localparam logic [CNT_WIDTH-1:0] MIN_P    = CNT_WIDTH'(NUM_CH + 3);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
   localparam logic [SEL_W-1:0]     SEL_ONE  = SEL_W'(1);
   localparam logic [SEL_W-1:0]     SEL_LAST = SEL_W'(NUM_CH - 1);

   pacer_state_t                     state_r;
   pacer_state_t                     state_s;
   logic [CNT_WIDTH-1:0]             cnt_r;
   logic [CNT_WIDTH-1:0]             p_eff_r;
   logic [CNT_WIDTH-1:0]             period_eff_s;
   logic                             count_last_s;
   logic [SEL_W-1:0]                 slot_r;
   logic                             rd_en_s;
   logic                             underrun_slot_s;
   logic                             cap_en_r;
   logic [SEL_W-1:0]                 cap_idx_r;
   logic [NUM_CH-1:0][IN_WIDTH-1:0]  ch_r;
   logic [OUT_WIDTH-1:0]             mix_s;

   assign period_eff_s = (period < MIN_P) ? MIN_P : period;
   // The last NUM_CH+2 cycles of the frame belong to READ, CAPTURE and MIX.
   assign count_last_s = (cnt_r == (p_eff_r - MIN_P));
   assign fifo_rd_en   = rd_en_s;

   // Next-state and read-strobe decode; enable low always returns to IDLE.
   always_comb begin
      state_s         = state_r;
      rd_en_s         = 1'b0;
      underrun_slot_s = 1'b0;
      if (!enable) begin
         state_s = IDLE;
      end else begin
         case (state_r)
            IDLE:    state_s = COUNT;
            COUNT:   state_s = count_last_s ? READ : COUNT;
            READ: begin
`ifdef AUDIO_PACER_UNDERRUN_EN
               rd_en_s         = ~fifo_empty;
               underrun_slot_s = fifo_empty;
`else
               rd_en_s         = 1'b1;
               underrun_slot_s = 1'b0;
`endif
               state_s = (slot_r == SEL_LAST) ? CAPTURE : READ;
            end
            CAPTURE: state_s = MIX;
            MIX:     state_s = COUNT;
            default: state_s = IDLE;
         endcase
      end
   end

   // State register, frame counter, period latch and read-slot index.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= IDLE;
         cnt_r   <= '0;
         p_eff_r <= MIN_P;
         slot_r  <= '0;
      end else begin
         state_r <= state_s;
         if ((state_s == COUNT) && (state_r != COUNT)) begin
            cnt_r   <= '0;
            p_eff_r <= period_eff_s;
         end else if (state_s == IDLE) begin
            cnt_r   <= '0;
         end else begin
            cnt_r   <= cnt_r + CNT_ONE;
         end
         if ((state_r == READ) && (state_s == READ)) begin
            slot_r <= slot_r + SEL_ONE;
         end else begin
            slot_r <= '0;
         end
      end
   end

   // FIFO data is valid the cycle after rd_en, so capture is one cycle behind.
   always_ff @(posedge clk) begin
      if (reset) begin
         cap_en_r  <= 1'b0;
         cap_idx_r <= '0;
         ch_r      <= '0;
      end else begin
         cap_en_r  <= rd_en_s;
         cap_idx_r <= slot_r;
         if (cap_en_r) begin
            ch_r[cap_idx_r] <= fifo_dout;
         end
      end
   end

   audio_channel_mixer #(
      .NUM_CH    (NUM_CH),
      .IN_WIDTH  (IN_WIDTH),
      .ADC_WIDTH (ADC_WIDTH),
      .OUT_WIDTH (OUT_WIDTH),
      .SEL_W     (SEL_W)
   ) u_mixer (
      .ch_flat  (ch_r),
      .mode     (mode),
      .chan_sel (chan_sel),
      .adc_data (adc_data),
      .mix_out  (mix_s)
   );

   // Output register: loads the mix result when MIX completes a full frame.
   always_ff @(posedge clk) begin
      if (reset) begin
         audio_data   <= '0;
         sample_valid <= 1'b0;
      end else if ((state_r == MIX) && enable) begin
         audio_data   <= mix_s;
         sample_valid <= 1'b1;
      end else begin
         sample_valid <= 1'b0;
      end
   end

`ifdef AUDIO_PACER_UNDERRUN_EN
   // Saturating count of read slots that found the FIFO empty.
   always_ff @(posedge clk) begin
      if (reset) begin
         underrun_count <= '0;
      end else if (underrun_slot_s) begin
         underrun_count <= sat_inc(underrun_count);
      end
   end
`else
   logic unused_s;
   assign unused_s       = fifo_empty ^ underrun_slot_s;
   assign underrun_count = '0;
`endif

endmodule

// File: tb/tb_audio_sample_pacer.sv
// Directed bench for audio_sample_pacer: a two-channel instance covers
// pacing, mixing modes, underrun behaviour and mid-frame reset; a
// four-channel instance covers the minimum-period clamp.
module tb_audio_sample_pacer;

   logic        clk = 1'b0;
   logic        reset, enable, enable4;
   logic [15:0] period;
   logic [1:0]  mode;
   logic        chan_sel;
   logic [1:0]  chan_sel4;
   logic [31:0] fifo_dout  = 32'h0;
   logic [31:0] fifo_dout4 = 32'h0;
   logic        fifo_empty;
   logic        fifo_rd_en, fifo_rd_en4;
   logic [23:0] adc_data;
   logic [11:0] audio_data, audio_data4;
   logic        sample_valid, sample_valid4;
   logic [15:0] underrun_count, underrun_count4;
   logic [31:0] w0, w1;
   int          rd_cnt  = 0;
   int          rd_cnt4 = 0;
   int          vectors = 0;
   int          miscompares = 0;

   always #5 clk = ~clk;

   audio_sample_pacer #(.NUM_CH(2)) dut (
      .clk(clk), .reset(reset), .enable(enable), .period(period), .mode(mode),
      .chan_sel(chan_sel), .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
      .fifo_rd_en(fifo_rd_en), .adc_data(adc_data), .audio_data(audio_data),
      .sample_valid(sample_valid), .underrun_count(underrun_count)
   );

   audio_sample_pacer #(.NUM_CH(4)) dut4 (
      .clk(clk), .reset(reset), .enable(enable4), .period(period), .mode(mode),
      .chan_sel(chan_sel4), .fifo_dout(fifo_dout4), .fifo_empty(1'b0),
      .fifo_rd_en(fifo_rd_en4), .adc_data(adc_data), .audio_data(audio_data4),
      .sample_valid(sample_valid4), .underrun_count(underrun_count4)
   );

   // Synchronous FIFO models: data appears the cycle after rd_en; words alternate w0/w1.
   always @(posedge clk) begin
      if (fifo_rd_en) begin
         fifo_dout <= rd_cnt[0] ? w1 : w0;
         rd_cnt    <= rd_cnt + 1;
      end
      if (fifo_rd_en4) begin
         fifo_dout4 <= 32'h1111_0000;
         rd_cnt4    <= rd_cnt4 + 1;
      end
   end

   // Counts clock edges until the selected instance pulses sample_valid (0 = timeout).
   task automatic wait_valid(input int which, input int limit, output int n);
      n = 0;
      for (int i = 1; i <= limit; i++) begin
         @(posedge clk); #1;
         if ((which == 0 && sample_valid) || (which == 1 && sample_valid4)) begin
            n = i;
            break;
         end
      end
   endtask

   task automatic test_reset;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      vectors++; if (fifo_rd_en !== 1'b0) begin miscompares++; $display("FAIL reset_rd_en got %b want 0", fifo_rd_en); end
      vectors++; if (sample_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b want 0", sample_valid); end
      vectors++; if (audio_data !== 12'h000) begin miscompares++; $display("FAIL reset_audio got %h want 000", audio_data); end
      vectors++; if (underrun_count !== 16'd0) begin miscompares++; $display("FAIL reset_underrun got %0d want 0", underrun_count); end
      vectors++; if (fifo_rd_en4 !== 1'b0) begin miscompares++; $display("FAIL reset_rd_en4 got %b want 0", fifo_rd_en4); end
      reset = 1'b0;
   endtask

   task automatic test_period_avg;
      int n, rc;
      period = 16'd100; mode = 2'd0; w0 = 32'h4000_0000; w1 = 32'h2000_0000;
      enable = 1'b1;
      wait_valid(0, 150, n);
      vectors++; if (n != 101) begin miscompares++; $display("FAIL avg_first_latency got %0d want 101", n); end
      vectors++; if (audio_data !== 12'h300) begin miscompares++; $display("FAIL avg_first_data got %h want 300", audio_data); end
      rc = rd_cnt;
      wait_valid(0, 150, n);
      vectors++; if (n != 100) begin miscompares++; $display("FAIL avg_interval got %0d want 100", n); end
      vectors++; if (audio_data !== 12'h300) begin miscompares++; $display("FAIL avg_data got %h want 300", audio_data); end
      vectors++; if (rd_cnt - rc != 2) begin miscompares++; $display("FAIL avg_reads got %0d want 2", rd_cnt - rc); end
   endtask

   task automatic test_no_wrap;
      int n;
      w0 = 32'h7FFF_FFFF; w1 = 32'h7FFF_FFFF; period = 16'd10;
      wait_valid(0, 150, n);
      vectors++; if (n != 100) begin miscompares++; $display("FAIL wrap_old_period got %0d want 100", n); end
      vectors++; if (audio_data !== 12'h7FF) begin miscompares++; $display("FAIL wrap_max got %h want 7ff", audio_data); end
      w0 = 32'h8000_0000; w1 = 32'h8000_0000;
      wait_valid(0, 30, n);
      vectors++; if (n != 10) begin miscompares++; $display("FAIL wrap_new_period got %0d want 10", n); end
      vectors++; if (audio_data !== 12'h800) begin miscompares++; $display("FAIL wrap_min got %h want 800", audio_data); end
   endtask

   task automatic test_single_channel;
      int n;
      mode = 2'd1; chan_sel = 1'b0; w0 = 32'h1230_0000; w1 = 32'h4560_0000;
      wait_valid(0, 30, n);
      vectors++; if (audio_data !== 12'h123) begin miscompares++; $display("FAIL single_ch0 got %h want 123", audio_data); end
      chan_sel = 1'b1;
      wait_valid(0, 30, n);
      vectors++; if (audio_data !== 12'h456) begin miscompares++; $display("FAIL single_ch1 got %h want 456", audio_data); end
   endtask

   task automatic test_adc_mute;
      int n, rc;
      mode = 2'd2; adc_data = 24'hABCDEF;
      wait_valid(0, 30, n);
      vectors++; if (audio_data !== 12'hABC) begin miscompares++; $display("FAIL adc_pass got %h want abc", audio_data); end
      mode = 2'd3; rc = rd_cnt;
      wait_valid(0, 30, n);
      vectors++; if (n != 10) begin miscompares++; $display("FAIL mute_interval got %0d want 10", n); end
      vectors++; if (audio_data !== 12'h000) begin miscompares++; $display("FAIL mute_data got %h want 000", audio_data); end
      vectors++; if (rd_cnt - rc != 2) begin miscompares++; $display("FAIL mute_reads got %0d want 2", rd_cnt - rc); end
      enable = 1'b0;
   endtask

   task automatic test_min_period;
      int n, rc, rc2;
      period = 16'd2; rc2 = rd_cnt;
      enable4 = 1'b1;
      wait_valid(1, 20, n);
      vectors++; if (n != 8) begin miscompares++; $display("FAIL minp_first got %0d want 8", n); end
      for (int f = 0; f < 2; f++) begin
         rc = rd_cnt4;
         wait_valid(1, 20, n);
         vectors++; if (n != 7) begin miscompares++; $display("FAIL minp_interval got %0d want 7", n); end
         vectors++; if (rd_cnt4 - rc != 4) begin miscompares++; $display("FAIL minp_reads got %0d want 4", rd_cnt4 - rc); end
      end
      vectors++; if (rd_cnt != rc2) begin miscompares++; $display("FAIL idle_no_reads got %0d want %0d", rd_cnt, rc2); end
      enable4 = 1'b0;
   endtask

   task automatic test_underrun;
      int n, rc;
      period = 16'd10; mode = 2'd0; w0 = 32'h4000_0000; w1 = 32'h2000_0000;
      enable = 1'b1;
      wait_valid(0, 30, n);
      vectors++; if (n != 11) begin miscompares++; $display("FAIL ur_frame1_latency got %0d want 11", n); end
      vectors++; if (audio_data !== 12'h300) begin miscompares++; $display("FAIL ur_frame1 got %h want 300", audio_data); end
      w0 = 32'h1000_0000; w1 = 32'h1000_0000;
      wait_valid(0, 30, n);
      vectors++; if (audio_data !== 12'h100) begin miscompares++; $display("FAIL ur_frame2 got %h want 100", audio_data); end
      fifo_empty = 1'b1; rc = rd_cnt;
      wait_valid(0, 30, n);
      vectors++; if (audio_data !== 12'h100) begin miscompares++; $display("FAIL ur_frame3 got %h want 100", audio_data); end
`ifdef AUDIO_PACER_UNDERRUN_EN
      vectors++; if (rd_cnt - rc != 0) begin miscompares++; $display("FAIL ur_reads got %0d want 0", rd_cnt - rc); end
      vectors++; if (underrun_count !== 16'd2) begin miscompares++; $display("FAIL ur_count got %0d want 2", underrun_count); end
`else
      vectors++; if (rd_cnt - rc != 2) begin miscompares++; $display("FAIL ur_reads got %0d want 2", rd_cnt - rc); end
      vectors++; if (underrun_count !== 16'd0) begin miscompares++; $display("FAIL ur_count got %0d want 0", underrun_count); end
`endif
      fifo_empty = 1'b0;
   endtask

   task automatic test_reset_mid_read;
      int n;
      bit found;
      found = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (fifo_rd_en) begin
            found = 1'b1;
            break;
         end
      end
      vectors++; if (!found) begin miscompares++; $display("FAIL mid_read_start got 0 want 1"); end
      @(posedge clk); #1;
      vectors++; if (fifo_rd_en !== 1'b1) begin miscompares++; $display("FAIL mid_read_slot2 got %b want 1", fifo_rd_en); end
      reset = 1'b1;
      @(posedge clk); #1;
      vectors++; if (fifo_rd_en !== 1'b0) begin miscompares++; $display("FAIL mid_rd_en got %b want 0", fifo_rd_en); end
      vectors++; if (sample_valid !== 1'b0) begin miscompares++; $display("FAIL mid_valid got %b want 0", sample_valid); end
      vectors++; if (audio_data !== 12'h000) begin miscompares++; $display("FAIL mid_audio got %h want 000", audio_data); end
      vectors++; if (underrun_count !== 16'd0) begin miscompares++; $display("FAIL mid_underrun got %0d want 0", underrun_count); end
      reset = 1'b0; w0 = 32'h6000_0000; w1 = 32'h2000_0000;
      wait_valid(0, 30, n);
      vectors++; if (n != 11) begin miscompares++; $display("FAIL mid_restart got %0d want 11", n); end
      vectors++; if (audio_data !== 12'h400) begin miscompares++; $display("FAIL mid_restart_data got %h want 400", audio_data); end
      enable = 1'b0;
   endtask

   initial begin
      reset = 1'b1; enable = 1'b0; enable4 = 1'b0; period = 16'd10; mode = 2'd0;
      chan_sel = 1'b0; chan_sel4 = 2'd0; fifo_empty = 1'b0; adc_data = 24'h0;
      w0 = 32'h0; w1 = 32'h0;
      test_reset;
      test_period_avg;
      test_no_wrap;
      test_single_channel;
      test_adc_mute;
      test_min_period;
      test_underrun;
      test_reset_mid_read;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
